// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM among NUM_REQ valid/ready
// requesters. Round-robin grant with an optional bounded burst lock, one
// registered command stage onto the SRAM pins, and a tag pipeline that steers
// read data back to the requester that issued it.
module sram_port_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int DATA_BIT  = 128,
  parameter int DEPTH     = 512,
  parameter int ADDR_BIT  = $clog2(DEPTH),
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_wen,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ*ADDR_BIT-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_BIT-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_BIT-1:0]          rsp_data,
  output logic [ADDR_BIT-1:0]          sram_addr,
  output logic                         sram_wen,
  output logic                         sram_ren,
  output logic [DATA_BIT-1:0]          sram_wdata,
  input  logic [DATA_BIT-1:0]          sram_rdata,
  output logic                         busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int LAST  = RD_LAT - 1;

  typedef enum logic {ST_ARB, ST_LOCK} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    rr_q, rr_d;

  logic [ADDR_BIT-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_BIT-1:0] sram_wdata_q, sram_wdata_d;
  logic                sram_wen_q, sram_wen_d;
  logic                sram_ren_q, sram_ren_d;
  logic [PTR_W-1:0]    iss_id_q, iss_id_d;

  logic [RD_LAT-1:0]   tag_vld_q;
  logic [PTR_W-1:0]    tag_id_q [RD_LAT];
  logic [DATA_BIT-1:0] rsp_hold_q;

  logic [NUM_REQ-1:0]  gnt;
  logic [PTR_W-1:0]    gnt_idx;
  logic                hs;
  logic                found;
  logic [PTR_W:0]      scan_sum;
  logic [PTR_W-1:0]    scan_idx;
  logic                rsp_fire;

  // Grant: locked owner only, otherwise first valid requester from rr_q upward.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    if (state_q == ST_LOCK) begin
      gnt[owner_q] = req_valid[owner_q];
      gnt_idx      = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_sum = {1'b0, rr_q} + (PTR_W+1)'(k);
        if (scan_sum >= (PTR_W+1)'(NUM_REQ)) scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
        scan_idx = scan_sum[PTR_W-1:0];
        if (!found && req_valid[scan_idx]) begin
          gnt[scan_idx] = 1'b1;
          gnt_idx       = scan_idx;
          found         = 1'b1;
        end
      end
    end
  end

  assign req_ready = gnt;
  assign hs        = |gnt;

  // Lock FSM, burst counter and round-robin pointer next state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    if (hs) rr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    case (state_q)
      ST_ARB: begin
        if (hs && req_lock[gnt_idx] && (MAX_BURST > 1)) begin
          state_d = ST_LOCK;
          owner_d = gnt_idx;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_LOCK: begin
        if (!req_valid[owner_q]) begin
          state_d = ST_ARB;
          cnt_d   = '0;
        end else if (!req_lock[owner_q] || cnt_q == CNT_W'(MAX_BURST - 1)) begin
          // Owner released the lock or just used its last burst slot.
          state_d = ST_ARB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_ARB;
        cnt_d   = '0;
      end
    endcase
  end

  // Command stage: capture the granted request; strobes drop when idle.
  always_comb begin
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    sram_wen_d   = 1'b0;
    sram_ren_d   = 1'b0;
    iss_id_d     = iss_id_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sram_addr_d  = req_addr[i*ADDR_BIT +: ADDR_BIT];
        sram_wdata_d = req_wdata[i*DATA_BIT +: DATA_BIT];
        sram_wen_d   = req_wen[i];
        sram_ren_d   = ~req_wen[i];
        iss_id_d     = PTR_W'(i);
      end
    end
  end

  // Control and command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      owner_q      <= '0;
      cnt_q        <= '0;
      rr_q         <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_wen_q   <= 1'b0;
      sram_ren_q   <= 1'b0;
      iss_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_wen_q   <= sram_wen_d;
      sram_ren_q   <= sram_ren_d;
      iss_id_q     <= iss_id_d;
    end
  end

  // Read tag pipeline: follows each issued read for RD_LAT cycles so the tag
  // lines up with the SRAM output; reset drops every outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) tag_id_q[s] <= '0;
    end else begin
      tag_vld_q[0] <= sram_ren_q;
      tag_id_q[0]  <= iss_id_q;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  assign rsp_fire = tag_vld_q[LAST];

  // Keep the last returned word so rsp_data is stable between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_hold_q <= '0;
    else if (rsp_fire) rsp_hold_q <= sram_rdata;
  end

  // Response steering: one-hot valid to the issuer, SRAM data passed through.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid[i] = rsp_fire && (tag_id_q[LAST] == PTR_W'(i));
  end

  assign rsp_data   = rsp_fire ? sram_rdata : rsp_hold_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_wen   = sram_wen_q;
  assign sram_ren   = sram_ren_q;
  assign busy       = sram_wen_q | sram_ren_q | (|tag_vld_q);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and randomized bench for sram_port_arbiter with a behavioural
// single-port SRAM (2-cycle registered read) and a response scoreboard.
module tb_sram_port_arbiter;

  localparam int N  = 3;
  localparam int DW = 128;
  localparam int AW = 9;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_wen, req_lock, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, sram_wdata, sram_rdata;
  logic [AW-1:0]   sram_addr;
  logic            sram_wen, sram_ren, busy;

  int n_tests = 0;
  int n_fail  = 0;

  sram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sram_addr(sram_addr), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: read sampled on the edge, data valid two cycles later.
  logic [DW-1:0] mem     [512];
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_wdata;
    if (sram_ren) rd_p0 <= mem[sram_addr];
    rd_p1 <= rd_p0;
  end
  assign sram_rdata = rd_p1;

  function automatic logic [DW-1:0] pat(input int a);
    logic [31:0] w;
    w = 32'h1000_0000 + 32'(a);
    return {4{w}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] w, input logic [N-1:0] l);
    req_valid = v;
    req_wen   = w;
    req_lock  = l;
  endtask

  typedef struct {
    int          due;
    logic [N-1:0] oh;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  logic [N-1:0] e3;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd_exp;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = pat(i);
    rst_n = 1'b0;
    drive('0, '0, '0);
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #4;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_sram_strobes", {sram_wen, sram_ren}, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_busy", busy, 0);
    next();

    // Round-robin reads from all three requesters, then drain.
    req_addr = {9'd30, 9'd20, 9'd10};
    drive(3'b111, 3'b000, 3'b000);
    for (int c = 0; c < 10; c++) begin
      if (c == 6) drive('0, '0, '0);
      #4;
      e3 = (c < 6) ? 3'(1 << (c % 3)) : 3'b000;
      chk("t1_ready", req_ready, e3);
      chk("t1_ren", sram_ren, (c >= 1 && c <= 6) ? 1 : 0);
      if (c >= 1 && c <= 6) chk("t1_addr", sram_addr, 10 * (((c - 1) % 3) + 1));
      if (c >= 3 && c <= 8) begin
        e3 = 3'(1 << ((c - 3) % 3));
        chk("t1_rsp_valid", rsp_valid, e3);
        chk("t1_rsp_data", rsp_data, pat(10 * (((c - 3) % 3) + 1)));
      end else begin
        chk("t1_rsp_idle", rsp_valid, 0);
      end
      if (c == 2) chk("t1_busy", busy, 1);
      if (c == 9) chk("t1_idle", busy, 0);
      next();
    end

    // Write from req1 followed by a read of the same address from req0.
    req_addr[AW +: AW]  = 9'd7;
    req_wdata[DW +: DW] = {16{8'hA5}};
    drive(3'b010, 3'b010, 3'b000);
    #4; chk("t2_wr_ready", req_ready, 3'b010);
    next();
    req_addr[0 +: AW] = 9'd7;
    drive(3'b001, 3'b000, 3'b000);
    #4; chk("t2_rd_ready", req_ready, 3'b001);
    chk("t2_wen", {sram_wen, sram_ren}, 2'b10);
    chk("t2_waddr", sram_addr, 7);
    chk("t2_wdata", sram_wdata, {16{8'hA5}});
    next();
    drive('0, '0, '0);
    #4; chk("t2_ren", {sram_wen, sram_ren}, 2'b01);
    chk("t2_raddr", sram_addr, 7);
    next();
    #4; chk("t2_no_wr_rsp", rsp_valid, 0);
    next();
    #4; chk("t2_rsp_valid", rsp_valid, 3'b001);
    chk("t2_rsp_data", rsp_data, {16{8'hA5}});
    next();
    #4; chk("t2_rsp_gone", rsp_valid, 0);
    chk("t2_rsp_hold", rsp_data, {16{8'hA5}});
    chk("t2_idle", busy, 0);
    next();

    // Req2 burst lock runs for MAX_BURST grants, then req0 wins.
    drive(3'b100, 3'b000, 3'b100);
    #4; chk("t3_first", req_ready, 3'b100);
    next();
    drive(3'b111, 3'b000, 3'b100);
    for (int k = 1; k < 8; k++) begin
      #4; chk("t3_locked", req_ready, 3'b100);
      next();
    end
    #4; chk("t3_after_burst", req_ready, 3'b001);
    next();
    drive('0, '0, '0);
    repeat (4) next();

    // Req1 locks, drops valid after three grants; req2 wins next.
    drive(3'b111, 3'b000, 3'b010);
    for (int k = 0; k < 3; k++) begin
      #4; chk("t4_locked", req_ready, 3'b010);
      next();
    end
    drive(3'b101, 3'b000, 3'b010);
    #4; chk("t4_release_cycle", req_ready, 3'b000);
    next();
    #4; chk("t4_resume_req2", req_ready, 3'b100);
    next();
    #4; chk("t4_then_req0", req_ready, 3'b001);
    next();
    drive('0, '0, '0);
    repeat (4) next();

    // Reset with two reads in flight.
    drive(3'b001, 3'b000, 3'b000);
    #4; chk("t5_rd0", req_ready, 3'b001);
    next();
    drive(3'b010, 3'b000, 3'b000);
    #4; chk("t5_rd1", req_ready, 3'b010);
    next();
    drive('0, '0, '0);
    chk("t5_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_ren_in_reset", sram_ren, 0);
    chk("t5_busy_in_reset", busy, 0);
    chk("t5_rsp_in_reset", rsp_valid, 0);
    next();
    next();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #4; chk("t5_no_stale_rsp", rsp_valid, 0);
      next();
    end

    // Randomized traffic against a grant-order reference memory.
    ref_mem = mem;
    for (int cyc = 0; cyc < 305; cyc++) begin
      if (cyc < 300) begin
        drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7) & $urandom_range(0, 7)));
        for (int i = 0; i < N; i++) begin
          req_addr[i*AW +: AW]  = 9'($urandom_range(0, 15));
          req_wdata[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        drive('0, '0, '0);
      end
      #4;
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("rnd_rsp_valid", rsp_valid, q[0].oh);
        chk("rnd_rsp_data", rsp_data, q[0].data);
        void'(q.pop_front());
      end else begin
        chk("rnd_rsp_idle", rsp_valid, 0);
      end
      chk("rnd_ready_onehot", $onehot0(req_ready), 1);
      chk("rnd_ready_subset", req_ready & ~req_valid, 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          ra = req_addr[i*AW +: AW];
          if (req_wen[i]) begin
            ref_mem[ra] = req_wdata[i*DW +: DW];
          end else begin
            rd_exp = ref_mem[ra];
            q.push_back('{due: cyc + 3, oh: 3'(1 << i), data: rd_exp});
          end
        end
      end
      next();
    end
    chk("rnd_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
